// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO and the fifo_reader skid-buffer front end.
package fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Occupancy of the two-entry skid buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  // Number of words held for a given occupancy state.
  function automatic logic [1:0] occ_level(input occ_t occ);
    logic [1:0] lvl;
    case (occ)
      EMPTY:   lvl = 2'd0;
      ONE:     lvl = 2'd1;
      TWO:     lvl = 2'd2;
      default: lvl = 2'd0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/fifo.sv
// Simple synchronous FIFO with registered read data (valid one cycle after rd).
// Synchronous active-low reset. depth must be a power of two.
module fifo
  import fifo_pkg::*;
#(
  parameter int width = DEFAULT_WIDTH,
  parameter int depth = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr,
  input  logic [width-1:0]             wdata,
  output logic                         full,
  input  logic                         rd,
  output logic [width-1:0]             rdata,
  output logic                         empty,
  output logic [$clog2(depth+1)-1:0]   level
);

  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(depth + 1);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             do_wr;
  logic             do_rd;

  // Status flags and qualified push/pop strobes.
  always_comb begin
    full  = (count == CW'(depth));
    empty = (count == {CW{1'b0}});
    level = count;
    do_wr = wr && !full;
    do_rd = rd && !empty;
  end

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointers, fill count and registered read port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr  <= {AW{1'b0}};
      rptr  <= {AW{1'b0}};
      count <= {CW{1'b0}};
      rdata <= {width{1'b0}};
    end else begin
      if (do_wr) begin
        wptr <= wptr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (do_rd) begin
        rdata <= mem[rptr];
        rptr  <= rptr + {{(AW-1){1'b0}}, 1'b1};
      end
      count <= count + {{(CW-1){1'b0}}, do_wr} - {{(CW-1){1'b0}}, do_rd};
    end
  end

endmodule

// File: rtl/skid_buffer.sv
// Two-entry skid buffer: two data registers addressed by a head select bit,
// with a small occupancy FSM (EMPTY/ONE/TWO).
module skid_buffer
  import fifo_pkg::*;
#(
  parameter int width = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture,
  input  logic             pop,
  input  logic [width-1:0] din,
  output occ_t             occ,
  output logic [width-1:0] dout
);

  occ_t             occ_q;
  occ_t             occ_d;
  logic [width-1:0] entry [2];
  logic             head;
  logic             tail;

  // Slot that the next captured word goes into: the head slot when empty,
  // otherwise the slot behind the head.
  always_comb begin
    tail = head;
    if (occ_q == EMPTY) begin
      tail = head;
    end else begin
      tail = ~head;
    end
  end

  // Occupancy next state: capture adds one, pop removes one, both cancel.
  always_comb begin
    occ_d = occ_q;
    case ({capture, pop})
      2'b10: begin
        case (occ_q)
          EMPTY:   occ_d = ONE;
          ONE:     occ_d = TWO;
          default: occ_d = occ_q;
        endcase
      end
      2'b01: begin
        case (occ_q)
          TWO:     occ_d = ONE;
          ONE:     occ_d = EMPTY;
          default: occ_d = occ_q;
        endcase
      end
      default: occ_d = occ_q;
    endcase
  end

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      occ_q <= EMPTY;
    end else begin
      occ_q <= occ_d;
    end
  end

  // Data entries and head select; a simultaneous capture lands behind the
  // surviving entry because tail is computed from the pre-pop head.
  always_ff @(posedge clk) begin
    if (!reset) begin
      entry[0] <= {width{1'b0}};
      entry[1] <= {width{1'b0}};
      head     <= 1'b0;
    end else begin
      if (capture) begin
        entry[tail] <= din;
      end
      if (pop) begin
        head <= ~head;
      end
    end
  end

  // Oldest entry is always presented.
  always_comb begin
    occ  = occ_q;
    dout = entry[head];
  end

  skid_buffer_checker u_checker (
    .clk   (clk),
    .reset (reset),
    .occ   (occ_q)
  );

endmodule

// File: rtl/skid_buffer_checker.sv
// Simulation checker: skid-buffer occupancy only ever moves by one level per edge.
module skid_buffer_checker
  import fifo_pkg::*;
(
  input logic clk,
  input logic reset,
  input occ_t occ
);

  property p_no_level_skip;
    @(posedge clk) disable iff (!reset)
      $past(reset) |-> !((($past(occ) == EMPTY) && (occ == TWO)) ||
                         (($past(occ) == TWO) && (occ == EMPTY)));
  endproperty

  a_no_level_skip: assert property (p_no_level_skip);

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: pulls words from a FIFO with one-cycle read latency and
// presents them on a valid/ready stream through a two-entry skid buffer.
// Optional macro FIFO_READER_STATS_EN adds a 16-bit wordCount output that
// counts completed transfers.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int width = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             empty,
  input  logic [width-1:0] fifoData,
  output logic             read,
  output logic             outValid,
  input  logic             outReady,
  output logic [width-1:0] outData
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [15:0]      wordCount
`endif
);

  occ_t       occ;
  logic       in_flight;
  logic       transfer;
  logic [2:0] reserved;
  logic [2:0] slots;

  // Read issue: a read is only issued when a slot is free for the word,
  // counting the word already in flight. A word leaving this cycle frees its
  // slot before the newly requested word can arrive, which keeps the
  // pipeline at one word per cycle while downstream is ready.
  always_comb begin
    transfer = outValid && outReady;
    reserved = {1'b0, occ_level(occ)} + {2'b00, in_flight};
    slots    = 3'd2 + {2'b00, transfer};
    read     = reset && !empty && (reserved < slots);
  end

  // inFlight tracks that the FIFO will present a word at the end of this cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_flight <= 1'b0;
    end else begin
      in_flight <= read;
    end
  end

  skid_buffer #(
    .width (width)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .capture (in_flight),
    .pop     (transfer),
    .din     (fifoData),
    .occ     (occ),
    .dout    (outData)
  );

  // Output valid whenever the skid buffer holds a word.
  always_comb begin
    outValid = (occ != EMPTY);
  end

`ifdef FIFO_READER_STATS_EN
  // Transfer counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wordCount <= 16'd0;
    end else if (transfer) begin
      wordCount <= wordCount + 16'd1;
    end else begin
      wordCount <= wordCount;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader driven from a depth-4 FIFO.
`timescale 1ns/1ps
module tb_fifo_reader;
  import fifo_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         wr = 1'b0;
  logic [W-1:0] wdata = 8'h00;
  logic         full;
  logic         empty;
  logic [W-1:0] fifoData;
  logic [2:0]   level;
  logic         read;
  logic         outValid;
  logic         outReady = 1'b0;
  logic [W-1:0] outData;
`ifdef FIFO_READER_STATS_EN
  logic [15:0]  wordCount;
`endif

  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] exp_q [$];
  int           cyc = 0;
  int           read_pulses = 0;
  int           xfers = 0;
  logic         gap_chk = 1'b0;
  int           last_xfer_cyc = -1;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = 8'h00;
  logic [W-1:0] exp_word;

  always #5 clk = ~clk;

  fifo #(.width(W), .depth(4)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (wr),
    .wdata (wdata),
    .full  (full),
    .rd    (read),
    .rdata (fifoData),
    .empty (empty),
    .level (level)
  );

  fifo_reader #(.width(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .empty    (empty),
    .fifoData (fifoData),
    .read     (read),
    .outValid (outValid),
    .outReady (outReady),
    .outData  (outData)
`ifdef FIFO_READER_STATS_EN
    ,
    .wordCount (wordCount)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] d);
    int guard = 0;
    while (full && guard < 50) begin
      tick();
      guard++;
    end
    if (full) begin
      miscompares++;
      $display("FAIL push_timeout: FIFO still full, word 0x%0h not written", d);
    end
    wr    = 1'b1;
    wdata = d;
    exp_q.push_back(d);
    tick();
    wr = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    check("drain_remaining", exp_q.size(), 0);
  endtask

  // Cycle counter used for the back-to-back transfer check.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops the scoreboard on every transfer and checks stall stability.
  initial forever begin
    @(negedge clk);
    if (read) read_pulses++;
    if (read && empty) begin
      miscompares++;
      $display("FAIL read_while_empty: read=1 with empty=1 (t=%0t)", $time);
    end
    if (reset && prev_stall) begin
      check("stall_valid_hold", outValid, 1);
      check("stall_data_hold", outData, prev_data);
    end
    prev_stall = reset && outValid && !outReady;
    prev_data  = outData;
    if (reset && outValid && outReady) begin
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_word: got 0x%0h, expected no transfer", outData);
      end else begin
        exp_word = exp_q.pop_front();
        check("out_data", outData, exp_word);
      end
      if (gap_chk && last_xfer_cyc >= 0) check("no_gap_cycle", cyc, last_xfer_cyc + 1);
      last_xfer_cyc = cyc;
      xfers++;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rp0;
    int x0;

    // Reset held for two cycles.
    reset = 1'b0;
    tick();
    tick();
    check("rst_read", read, 0);
    check("rst_out_valid", outValid, 0);
    check("rst_out_data", outData, 8'h00);
`ifdef FIFO_READER_STATS_EN
    check("rst_word_count", wordCount, 0);
`endif
    reset = 1'b1;
    tick();

    // Single word: read one cycle after the write, word visible two later.
    outReady = 1'b1;
    rp0 = read_pulses;
    push_word(8'h88);
    check("s2_read_hi", read, 1);
    tick();
    check("s2_read_lo", read, 0);
    check("s2_valid_lo", outValid, 0);
    tick();
    check("s2_valid_hi", outValid, 1);
    check("s2_data", outData, 8'h88);
    tick();
    check("s2_valid_after", outValid, 0);
    check("s2_fifo_empty", empty, 1);
    check("s2_read_pulses", read_pulses - rp0, 1);

    // Sixteen words streamed with downstream always ready.
    gap_chk = 1'b1;
    last_xfer_cyc = -1;
    x0 = xfers;
    for (int i = 0; i < 16; i++) push_word(8'(i));
    drain(40);
    gap_chk = 1'b0;
    check("s3_xfer_count", xfers - x0, 16);

    // Backpressure: four words queued, downstream stalled.
    outReady = 1'b0;
    rp0 = read_pulses;
    for (int i = 0; i < 4; i++) push_word(8'(i));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s4_hold_valid", outValid, 1);
      check("s4_hold_data", outData, 8'h00);
    end
    check("s4_read_pulses", read_pulses - rp0, 2);
    check("s4_fifo_level", level, 2);
    outReady = 1'b1;
    drain(20);

    // Reset while words sit in the buffer, in flight and in the FIFO.
    outReady = 1'b0;
    push_word(8'h10);
    push_word(8'h11);
    push_word(8'h12);
    check("s5_pre_valid", outValid, 1);
    reset = 1'b0;
    exp_q.delete();
    tick();
    check("s5_valid_cleared", outValid, 0);
    check("s5_read_cleared", read, 0);
    check("s5_data_cleared", outData, 8'h00);
    reset = 1'b1;
    tick();
    x0 = xfers;
    outReady = 1'b1;
    push_word(8'hA5);
    drain(10);
    check("s5_one_xfer", xfers - x0, 1);

`ifdef FIFO_READER_STATS_EN
    // Counter wrap after 65537 transfers.
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    check("s6_count_reset", wordCount, 0);
    for (int i = 0; i < 65537; i++) push_word(8'(i));
    drain(20);
    tick();
    check("s6_count_wrap", wordCount, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
